// File: rtl/dac714_ser_out.sv
// rtl/dac714_ser_out.sv - serializes a saturated 16-bit ramp sample into a DAC714 (SDI/SCLK/nLatch)
module dac714_ser_out #(
    parameter int CLK_DIV = 4,
    parameter int SHIFT   = 0
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        DACStrobe,
    input  logic [63:0] Yis,
    output logic        SDI,
    output logic        SCLK,
    output logic        nLatch,
    output logic        Busy,
    output logic        Sat,
    output logic        Overrun,
    output logic [7:0]  OverrunCnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      r_state, w_state_n;
    logic [7:0]  r_div, w_div_n;
    logic [3:0]  r_bit, w_bit_n;
    logic [15:0] r_shift, w_shift_n;
    logic        r_sdi, w_sdi_n;
    logic        r_sclk, w_sclk_n;
    logic        r_nlatch, w_nlatch_n;
    logic        r_lphase, w_lphase_n;
    logic        r_busy, w_busy_n;
    logic        r_sat, w_sat_n;
    logic        r_overrun, w_overrun_n;
    logic [7:0]  r_ocnt, w_ocnt_n;
    logic        r_strobe_prev;

    logic               w_edge;
    logic signed [63:0] w_shifted;
    logic               w_hi;
    logic               w_lo;
    logic [15:0]        w_sample;

    assign w_edge    = DACStrobe & ~r_strobe_prev;
    assign w_shifted = $signed(Yis) >>> SHIFT;
    assign w_hi      = w_shifted > 64'sd32767;
    assign w_lo      = w_shifted < -64'sd32768;
    assign w_sample  = w_hi ? 16'h7FFF : (w_lo ? 16'h8000 : w_shifted[15:0]);

    // Strobe history runs every cycle so edges are seen regardless of state
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_strobe_prev <= 1'b1;
        end else begin
            r_strobe_prev <= DACStrobe;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_div     <= 8'd0;
            r_bit     <= 4'd0;
            r_shift   <= 16'd0;
            r_sdi     <= 1'b0;
            r_sclk    <= 1'b0;
            r_nlatch  <= 1'b1;
            r_lphase  <= 1'b0;
            r_busy    <= 1'b0;
            r_sat     <= 1'b0;
            r_overrun <= 1'b0;
            r_ocnt    <= 8'd0;
        end else begin
            r_state   <= w_state_n;
            r_div     <= w_div_n;
            r_bit     <= w_bit_n;
            r_shift   <= w_shift_n;
            r_sdi     <= w_sdi_n;
            r_sclk    <= w_sclk_n;
            r_nlatch  <= w_nlatch_n;
            r_lphase  <= w_lphase_n;
            r_busy    <= w_busy_n;
            r_sat     <= w_sat_n;
            r_overrun <= w_overrun_n;
            r_ocnt    <= w_ocnt_n;
        end
    end

    // Next-state: capture in IDLE, clock bits out in SHIFT, setup gap then load pulse in LATCH
    always_comb begin
        w_state_n   = r_state;
        w_div_n     = r_div;
        w_bit_n     = r_bit;
        w_shift_n   = r_shift;
        w_sdi_n     = r_sdi;
        w_sclk_n    = r_sclk;
        w_nlatch_n  = r_nlatch;
        w_lphase_n  = r_lphase;
        w_busy_n    = r_busy;
        w_sat_n     = r_sat;
        w_overrun_n = 1'b0;
        w_ocnt_n    = r_ocnt;

        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_shift_n = w_sample;
                    w_bit_n   = 4'd15;
                    w_sdi_n   = w_sample[15];
                    w_sclk_n  = 1'b0;
                    w_busy_n  = 1'b1;
                    w_sat_n   = w_hi | w_lo;
                    w_div_n   = 8'd0;
                    w_state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_div_n = 8'd0;
                    if (!r_sclk) begin
                        w_sclk_n = 1'b1;
                    end else begin
                        // Data only moves on the falling SCLK edge
                        w_sclk_n  = 1'b0;
                        w_shift_n = {r_shift[14:0], 1'b0};
                        if (r_bit == 4'd0) begin
                            w_sdi_n    = 1'b0;
                            w_lphase_n = 1'b0;
                            w_state_n  = S_LATCH;
                        end else begin
                            w_sdi_n = r_shift[14];
                            w_bit_n = r_bit - 4'd1;
                        end
                    end
                end else begin
                    w_div_n = r_div + 8'd1;
                end
            end
            S_LATCH: begin
                // First CLK_DIV cycles are SCLK-low setup, then nLatch low CLK_DIV cycles
                if (r_div == DIV_LAST) begin
                    w_div_n = 8'd0;
                    if (!r_lphase) begin
                        w_lphase_n = 1'b1;
                        w_nlatch_n = 1'b0;
                    end else begin
                        w_lphase_n = 1'b0;
                        w_nlatch_n = 1'b1;
                        w_busy_n   = 1'b0;
                        w_state_n  = S_IDLE;
                    end
                end else begin
                    w_div_n = r_div + 8'd1;
                end
            end
            default: begin
                w_state_n  = S_IDLE;
                w_sclk_n   = 1'b0;
                w_nlatch_n = 1'b1;
                w_busy_n   = 1'b0;
            end
        endcase

        // Any edge outside IDLE is dropped and counted
        if (w_edge && (r_state != S_IDLE)) begin
            w_overrun_n = 1'b1;
            if (r_ocnt != 8'hFF) begin
                w_ocnt_n = r_ocnt + 8'd1;
            end
        end
    end

    assign SDI        = r_sdi;
    assign SCLK       = r_sclk;
    assign nLatch     = r_nlatch;
    assign Busy       = r_busy;
    assign Sat        = r_sat;
    assign Overrun    = r_overrun;
    assign OverrunCnt = r_ocnt;

endmodule

// File: tb/tb_dac714_ser_out.sv
// tb/tb_dac714_ser_out.sv - self-checking bench for dac714_ser_out
module tb_dac714_ser_out;

    logic        clk;
    logic        rst;
    logic [2:0]  strobe;
    logic [63:0] yis [3];
    logic [2:0]  sdi, sclk, nlatch, busy, sat, ovr;
    logic [7:0]  ocnt [3];

    int n_cmp;
    int n_fail;

    dac714_ser_out #(.CLK_DIV(4), .SHIFT(0)) u_a (
        .clk(clk), .Reset(rst), .DACStrobe(strobe[0]), .Yis(yis[0]),
        .SDI(sdi[0]), .SCLK(sclk[0]), .nLatch(nlatch[0]), .Busy(busy[0]),
        .Sat(sat[0]), .Overrun(ovr[0]), .OverrunCnt(ocnt[0])
    );
    dac714_ser_out #(.CLK_DIV(4), .SHIFT(16)) u_b (
        .clk(clk), .Reset(rst), .DACStrobe(strobe[1]), .Yis(yis[1]),
        .SDI(sdi[1]), .SCLK(sclk[1]), .nLatch(nlatch[1]), .Busy(busy[1]),
        .Sat(sat[1]), .Overrun(ovr[1]), .OverrunCnt(ocnt[1])
    );
    dac714_ser_out #(.CLK_DIV(1), .SHIFT(0)) u_c (
        .clk(clk), .Reset(rst), .DACStrobe(strobe[2]), .Yis(yis[2]),
        .SDI(sdi[2]), .SCLK(sclk[2]), .nLatch(nlatch[2]), .Busy(busy[2]),
        .Sat(sat[2]), .Overrun(ovr[2]), .OverrunCnt(ocnt[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int div_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic int shift_of(input int k);
        return (k == 1) ? 16 : 0;
    endfunction

    // Reference: {sat, word} from plain signed arithmetic
    function automatic logic [16:0] model(input logic [63:0] y, input int sh);
        longint v;
        v = longint'($signed(y)) >>> sh;
        if (v > 64'sd32767)  return {1'b1, 16'h7FFF};
        if (v < -64'sd32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input int k, input string tag);
        check({tag, " SDI"},        64'(sdi[k]),    64'd0);
        check({tag, " SCLK"},       64'(sclk[k]),   64'd0);
        check({tag, " nLatch"},     64'(nlatch[k]), 64'd1);
        check({tag, " Busy"},       64'(busy[k]),   64'd0);
        check({tag, " Sat"},        64'(sat[k]),    64'd0);
        check({tag, " Overrun"},    64'(ovr[k]),    64'd0);
        check({tag, " OverrunCnt"}, 64'(ocnt[k]),   64'd0);
    endtask

    // One conversion: strobe, watch the wire protocol, scramble Yis afterwards
    task automatic xfer(input int k, input logic [63:0] y, input int extra_at,
                        output logic [15:0] word, output int busy_n, output int nl_n,
                        output int viol, output int ov_n, output bit done);
        int  budget;
        bit  seen;
        logic psclk, psdi;
        budget = 40 * div_of(k) + 40;
        word = 16'd0; busy_n = 0; nl_n = 0; viol = 0; ov_n = 0; done = 1'b0;
        seen = 1'b0; psclk = 1'b0; psdi = 1'b0;
        @(negedge clk);
        strobe[k] = 1'b1;
        yis[k]    = y;
        for (int c = 1; c <= budget && !done; c++) begin
            @(negedge clk);
            if (c == 1) strobe[k] = 1'b0;
            if (extra_at != 0 && c == extra_at)     strobe[k] = 1'b1;
            if (extra_at != 0 && c == extra_at + 1) strobe[k] = 1'b0;
            yis[k] = {$urandom, $urandom};
            if (busy[k]) begin
                busy_n++;
                seen = 1'b1;
            end
            if (sclk[k] && !psclk) word = {word[14:0], sdi[k]};
            if (sclk[k] && psclk && (sdi[k] != psdi)) viol++;
            if (!nlatch[k]) nl_n++;
            if (ovr[k]) ov_n++;
            psclk = sclk[k];
            psdi  = sdi[k];
            if (seen && !busy[k]) done = 1'b1;
        end
    endtask

    task automatic run_check(input int k, input logic [63:0] y, input logic [15:0] exp_w,
                             input logic exp_s, input string tag);
        logic [15:0] w;
        int bn, nn, vi, on;
        bit dn;
        xfer(k, y, 0, w, bn, nn, vi, on, dn);
        check({tag, " done"},     64'(dn), 64'd1);
        check({tag, " word"},     64'(w),  64'(exp_w));
        check({tag, " busy_cyc"}, 64'(bn), 64'(34 * div_of(k)));
        check({tag, " nlat_cyc"}, 64'(nn), 64'(div_of(k)));
        check({tag, " sdi_hi"},   64'(vi), 64'd0);
        check({tag, " overrun"},  64'(on), 64'd0);
        check({tag, " sat"},      64'(sat[k]), 64'(exp_s));
    endtask

    typedef struct {
        int          k;
        logic [63:0] y;
        logic [15:0] w;
        logic        s;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [15:0] w;
        logic [16:0] m;
        logic [63:0] r, y;
        int bn, nn, vi, on, k, nl, dropped, pulses, exp_ocnt;
        bit dn;

        n_cmp = 0;
        n_fail = 0;

        tbl[0]  = '{0, 64'h0000_0000_0000_1234, 16'h1234, 1'b0};
        tbl[1]  = '{1, 64'h0000_0001_2345_0000, 16'h7FFF, 1'b1};
        tbl[2]  = '{1, 64'hFFFF_FF00_0000_0000, 16'h8000, 1'b1};
        tbl[3]  = '{2, 64'hFFFF_FFFF_FFFF_8000, 16'h8000, 1'b0};
        tbl[4]  = '{0, 64'h0000_0000_0000_7FFF, 16'h7FFF, 1'b0};
        tbl[5]  = '{0, 64'h0000_0000_0000_8000, 16'h7FFF, 1'b1};
        tbl[6]  = '{0, 64'hFFFF_FFFF_FFFF_7FFF, 16'h8000, 1'b1};
        tbl[7]  = '{2, 64'h0000_0000_0000_0000, 16'h0000, 1'b0};
        tbl[8]  = '{1, 64'h0000_0000_7FFF_FFFF, 16'h7FFF, 1'b0};
        tbl[9]  = '{1, 64'h8000_0000_0000_0000, 16'h8000, 1'b1};
        tbl[10] = '{1, 64'hFFFF_FFFF_8000_0000, 16'h8000, 1'b0};

        // Reset with strobe 0 already high: release must not start a conversion
        rst    = 1'b1;
        strobe = 3'b001;
        for (int i = 0; i < 3; i++) yis[i] = 64'h1234;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset_vals(i, "reset");
        rst = 1'b0;
        nl = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy[0]) nl++;
        end
        check("strobe_high_at_release busy", 64'(nl), 64'd0);
        strobe = 3'b000;
        repeat (2) @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 11; i++)
            run_check(tbl[i].k, tbl[i].y, tbl[i].w, tbl[i].s, $sformatf("tbl%0d", i));

        // Second edge 20 cycles into a transfer is dropped
        exp_ocnt = 0;
        xfer(0, 64'h0000_0000_0000_1234, 20, w, bn, nn, vi, on, dn);
        exp_ocnt++;
        check("ovr20 done",     64'(dn), 64'd1);
        check("ovr20 word",     64'(w),  64'h1234);
        check("ovr20 pulses",   64'(on), 64'd1);
        check("ovr20 cnt",      64'(ocnt[0]), 64'(exp_ocnt));
        check("ovr20 busy_cyc", 64'(bn), 64'd136);

        // 300 dropped edges saturate the counter
        dropped = 0;
        pulses  = 0;
        for (int c = 0; c < 3000 && dropped < 300; c++) begin
            @(negedge clk);
            if (ovr[0]) pulses++;
            if (strobe[0]) begin
                strobe[0] = 1'b0;
            end else begin
                if (busy[0]) dropped++;
                strobe[0] = 1'b1;
            end
        end
        repeat (3) begin
            @(negedge clk);
            strobe[0] = 1'b0;
            if (ovr[0]) pulses++;
        end
        exp_ocnt = (exp_ocnt + dropped > 255) ? 255 : exp_ocnt + dropped;
        check("ovr300 dropped", 64'(dropped), 64'd300);
        check("ovr300 pulses",  64'(pulses),  64'd300);
        check("ovr300 cnt",     64'(ocnt[0]), 64'(exp_ocnt));
        nl = 0;
        for (int c = 0; c < 300 && busy[0]; c++) begin
            @(negedge clk);
            nl++;
        end
        check("ovr300 idle", 64'(busy[0]), 64'd0);

        // Reset 50 cycles into a saturating transfer: immediate reset, no load pulse
        @(negedge clk);
        strobe[0] = 1'b1;
        yis[0]    = 64'h0000_0000_0001_0000;
        nl = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            strobe[0] = 1'b0;
            if (!nlatch[0]) nl++;
        end
        check("midrst sat_before", 64'(sat[0]), 64'd1);
        #2 rst = 1'b1;
        #1 check_reset_vals(0, "midrst");
        repeat (3) begin
            @(negedge clk);
            if (!nlatch[0]) nl++;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!nlatch[0]) nl++;
        end
        check("midrst no_latch", 64'(nl), 64'd0);
        run_check(0, 64'h0000_0000_0000_00C3, 16'h00C3, 1'b0, "postrst");

        // Randomized transfers against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 2);
            r = {$urandom, $urandom};
            y = 64'($signed(r) >>> $urandom_range(0, 63));
            m = model(y, shift_of(k));
            run_check(k, y, m[15:0], m[16], $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dac714_ser_out.md
DAC714_SER_OUT -- requirements
Module: dac714_ser_out

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have parameter SHIFT, default 0: arithmetic right-shift applied to Yis before saturation; legal range 0..48.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 Reset  in  1  asynchronous active-high reset.
REQ-006 DACStrobe  in  1  level from the ramp generator; each rising edge requests one conversion.
REQ-007 Yis  in  64  signed ramp output value; sampled on the accepted strobe edge.
REQ-008 SDI  out  1  serial data to DAC714, MSB first.
REQ-009 SCLK  out  1  serial clock to DAC714; data sampled by the DAC on its rising edge.
REQ-010 nLatch  out  1  active-low DAC load pulse (drives A0/A1 tied).
REQ-011 Busy  out  1  high from strobe acceptance until the end of the latch pulse.
REQ-012 Sat  out  1  high if the last captured sample was clipped.
REQ-013 Overrun  out  1  one-cycle pulse when a strobe edge is dropped.
REQ-014 OverrunCnt  out  8  saturating count of dropped strobe edges.

Function
REQ-015 SHALL detect a strobe edge as DACStrobe=1 with a registered previous value of 0; the previous-value register SHALL be clocked every cycle, independent of state.
REQ-016 SHALL implement the states IDLE, SHIFT and LATCH.
REQ-017 IDLE + edge: at that clk edge the block SHALL capture sample = sat16(Yis >>> SHIFT), load the 16-bit shift register, set bit counter=15, set SDI=sample[15], SCLK=0, Busy=1, and go to SHIFT.
REQ-018 sat16: if the shifted value exceeds 32767 the sample SHALL be 0x7FFF; if below -32768 it SHALL be 0x8000; otherwise it SHALL be the low 16 bits. Output is two's complement.
REQ-019 Sat SHALL update on each capture and hold until the next capture.
REQ-020 SHIFT: each bit occupies 2*CLK_DIV cycles, SCLK low for CLK_DIV cycles then high for CLK_DIV cycles.
REQ-021 SHIFT: SDI SHALL change only on the cycle SCLK goes 1->0, never while SCLK=1.
REQ-022 SHIFT: after the high phase of bit 0, SCLK SHALL go to 0 and the state SHALL go to LATCH.
REQ-023 LATCH: nLatch SHALL be 0 for exactly CLK_DIV cycles, then return to 1, Busy SHALL go to 0, and the state SHALL go to IDLE.
REQ-024 Busy SHALL stay high for exactly 34*CLK_DIV cycles per conversion.
REQ-025 A strobe edge in SHIFT or LATCH SHALL be dropped: Overrun pulses for 1 cycle, OverrunCnt increments, saturating at 255, and the transfer in progress continues unaffected.
REQ-026 An edge on the same cycle as the return to IDLE SHALL be dropped; acceptance requires state==IDLE at that edge.
REQ-027 Yis changes outside the capture cycle SHALL have no effect on the transfer in progress.
REQ-028 Outside SHIFT, SCLK SHALL be 0; outside LATCH, nLatch SHALL be 1.

Reset
REQ-029 While Reset=1, and asynchronously on assertion, the block SHALL force: state=IDLE, SDI=0, SCLK=0, nLatch=1, Busy=0, Sat=0, Overrun=0, OverrunCnt=0, shift register=0, strobe-previous register=1.
REQ-030 Because strobe-previous resets to 1, a DACStrobe already high at reset release SHALL not start a conversion.
REQ-031 Reset asserted mid-transfer SHALL abort the transfer with no nLatch pulse.

Verification
REQ-032 CLK_DIV=4, SHIFT=0, Yis=0x1234, one strobe edge -> SDI bits on SCLK rises read 0x1234; nLatch low 4 cycles; Busy high 136 cycles; Sat=0.
REQ-033 SHIFT=16, Yis=0x0000_0001_2345_0000 -> serialized 0x7FFF, Sat=1; Yis=-2^40 -> 0x8000, Sat=1.
REQ-034 Second strobe edge 20 cycles after the first -> one Overrun pulse, OverrunCnt=1, first word unchanged; 300 dropped edges -> OverrunCnt=255.
REQ-035 Reset pulsed at cycle 50 of a transfer -> all outputs at reset values immediately, no nLatch low, next strobe edge transfers correctly.
REQ-036 CLK_DIV=1, Yis=0xFFFF_FFFF_FFFF_8000 -> word 0x8000, Sat=0, Busy high 34 cycles, SDI never toggles while SCLK=1.
